// File: rtl/btn_conditioner_if.sv
// Raw board inputs and conditioned outputs exchanged between the input
// conditioner (slave) and whatever drives/consumes it (master).
interface btn_conditioner_if;
    logic BtnL;
    logic BtnR;
    logic Sw0;
    logic Sw1;
    logic BtnL_level;
    logic BtnR_level;
    logic BtnL_pulse;
    logic BtnR_pulse;
    logic Sw0_db;
    logic Sw1_db;

    modport slave (
        input  BtnL,
        input  BtnR,
        input  Sw0,
        input  Sw1,
        output BtnL_level,
        output BtnR_level,
        output BtnL_pulse,
        output BtnR_pulse,
        output Sw0_db,
        output Sw1_db
    );

    modport master (
        output BtnL,
        output BtnR,
        output Sw0,
        output Sw1,
        input  BtnL_level,
        input  BtnR_level,
        input  BtnL_pulse,
        input  BtnR_pulse,
        input  Sw0_db,
        input  Sw1_db
    );
endinterface

// File: rtl/btn_conditioner.sv
// Input conditioner: 2-flop sync + debounce on BtnL/BtnR/Sw0/Sw1, plus one-cycle
// press pulses with optional hold-to-repeat on the two buttons.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input logic              Clk,
    input logic              Reset,
    btn_conditioner_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W = $clog2(RMAX + 1);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] DLY_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] PER_LAST = RC_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    // Bit order everywhere: 0 BtnL, 1 BtnR, 2 Sw0, 3 Sw1
    logic [3:0] raw_vec;
    logic [3:0] db_vec;
    logic [3:0] level_vec;
    logic [1:0] pulse_vec;

    assign raw_vec = {bus.Sw1, bus.Sw0, bus.BtnR, bus.BtnL};

    genvar gi;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_in
            logic            s1_reg;
            logic            s2_reg;
            logic            db_reg;
            logic            level_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    db_reg    <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    s1_reg    <= raw_vec[gi];
                    s2_reg    <= s1_reg;
                    level_reg <= db_reg;
                    // Any cycle of agreement restarts the disagreement run
                    if (s2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        db_reg  <= s2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DB_W'(1);
                    end
                end
            end

            assign db_vec[gi]    = db_reg;
            assign level_vec[gi] = level_reg;
        end
    endgenerate

    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            rpt_state_t      state_reg;
            logic [RC_W-1:0] rcnt_reg;
            logic            pulse_reg;

            // level_reg is db delayed by one cycle, so db & ~level marks the rising edge
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    state_reg <= ST_IDLE;
                    rcnt_reg  <= '0;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= 1'b0;
                    if (!db_vec[gi]) begin
                        state_reg <= ST_IDLE;
                        rcnt_reg  <= '0;
                    end else begin
                        case (state_reg)
                            ST_IDLE: begin
                                if (!level_vec[gi]) begin
                                    pulse_reg <= 1'b1;
                                    rcnt_reg  <= '0;
                                    if (REPEAT_EN != 0) begin
                                        state_reg <= ST_WAIT;
                                    end
                                end
                            end
                            ST_WAIT: begin
                                // An expiry right after a pulse is held one cycle so pulses never touch
                                if (rcnt_reg == DLY_LAST) begin
                                    if (!pulse_reg) begin
                                        pulse_reg <= 1'b1;
                                        rcnt_reg  <= '0;
                                        state_reg <= ST_REPEAT;
                                    end
                                end else begin
                                    rcnt_reg <= rcnt_reg + RC_W'(1);
                                end
                            end
                            ST_REPEAT: begin
                                if (rcnt_reg == PER_LAST) begin
                                    if (!pulse_reg) begin
                                        pulse_reg <= 1'b1;
                                        rcnt_reg  <= '0;
                                    end
                                end else begin
                                    rcnt_reg <= rcnt_reg + RC_W'(1);
                                end
                            end
                            default: begin
                                state_reg <= ST_IDLE;
                                rcnt_reg  <= '0;
                            end
                        endcase
                    end
                end
            end

            assign pulse_vec[gi] = pulse_reg;
        end
    endgenerate

    assign bus.BtnL_level = level_vec[0];
    assign bus.BtnR_level = level_vec[1];
    assign bus.Sw0_db     = level_vec[2];
    assign bus.Sw1_db     = level_vec[3];
    assign bus.BtnL_pulse = pulse_vec[0];
    assign bus.BtnR_pulse = pulse_vec[1];
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: three parameterisations driven by the same raw inputs,
// checked every cycle against a time-based reference model plus directed scenarios.
module tb_btn_conditioner;
    localparam int DB = 4;

    logic clk;
    logic rst;
    logic btn_l, btn_r, sw0, sw1;

    btn_conditioner_if if_a ();
    btn_conditioner_if if_b ();
    btn_conditioner_if if_c ();

    assign if_a.BtnL = btn_l;  assign if_a.BtnR = btn_r;  assign if_a.Sw0 = sw0;  assign if_a.Sw1 = sw1;
    assign if_b.BtnL = btn_l;  assign if_b.BtnR = btn_r;  assign if_b.Sw0 = sw0;  assign if_b.Sw1 = sw1;
    assign if_c.BtnL = btn_l;  assign if_c.BtnR = btn_r;  assign if_c.Sw0 = sw0;  assign if_c.Sw1 = sw1;

    btn_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8))
        u_a (.Clk(clk), .Reset(rst), .bus(if_a));
    btn_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8))
        u_b (.Clk(clk), .Reset(rst), .bus(if_b));
    btn_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(1), .REPEAT_PERIOD(1))
        u_c (.Clk(clk), .Reset(rst), .bus(if_c));

    // Output bits: 0 BtnL_level, 1 BtnR_level, 2 BtnL_pulse, 3 BtnR_pulse, 4 Sw0_db, 5 Sw1_db
    logic [5:0] obs [3];
    assign obs[0] = {if_a.Sw1_db, if_a.Sw0_db, if_a.BtnR_pulse, if_a.BtnL_pulse, if_a.BtnR_level, if_a.BtnL_level};
    assign obs[1] = {if_b.Sw1_db, if_b.Sw0_db, if_b.BtnR_pulse, if_b.BtnL_pulse, if_b.BtnR_level, if_b.BtnL_level};
    assign obs[2] = {if_c.Sw1_db, if_c.Sw0_db, if_c.BtnR_pulse, if_c.BtnL_pulse, if_c.BtnR_level, if_c.BtnL_level};

    string out_nm [6] = '{"BtnL_level", "BtnR_level", "BtnL_pulse", "BtnR_pulse", "Sw0_db", "Sw1_db"};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // samp_m1/samp_m2: raw value taken one / two edges ago (0 if that edge was in reset).
    // Debounced value flips once the synchronised input has disagreed for DB edges in a row.
    // Pulses: rising level, then repeats at fixed offsets from the press while held.
    int cyc = 0;
    bit samp_m1 [4];
    bit samp_m2 [4];
    bit m_db    [4];
    int m_run   [4];
    bit m_lvl   [4];
    int press_t [2];
    bit exp_pulse [3][2];

    function automatic bit rep_due(input int d, input int en, input int dly, input int per);
        int de;
        int pe;
        if (en == 0) return 1'b0;
        de = (dly < 2) ? 2 : dly;
        pe = (per < 2) ? 2 : per;
        if (d == de) return 1'b1;
        if (d > de && ((d - de) % pe) == 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit r [4];
        bit nl [4];
        bit rise;
        r[0] = btn_l; r[1] = btn_r; r[2] = sw0; r[3] = sw1;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                samp_m1[i] = 1'b0; samp_m2[i] = 1'b0;
                m_db[i] = 1'b0; m_run[i] = 0; m_lvl[i] = 1'b0;
            end
            for (int j = 0; j < 3; j++) begin
                exp_pulse[j][0] = 1'b0; exp_pulse[j][1] = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 4; i++) begin
                nl[i] = m_db[i];
                if (samp_m2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_db[i]  = samp_m2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            for (int b = 0; b < 2; b++) begin
                rise = nl[b] && !m_lvl[b];
                if (rise) press_t[b] = cyc;
                exp_pulse[0][b] = rise || (nl[b] && m_lvl[b] && rep_due(cyc - press_t[b], 1, 20, 8));
                exp_pulse[1][b] = rise || (nl[b] && m_lvl[b] && rep_due(cyc - press_t[b], 0, 20, 8));
                exp_pulse[2][b] = rise || (nl[b] && m_lvl[b] && rep_due(cyc - press_t[b], 1, 1, 1));
            end
            for (int i = 0; i < 4; i++) begin
                m_lvl[i]   = nl[i];
                samp_m2[i] = samp_m1[i];
                samp_m1[i] = r[i];
            end
        end
    end

    // Advance one cycle and compare every output of every instance to the model
    task automatic tick();
        logic [5:0] want;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            want = {m_lvl[3], m_lvl[2], exp_pulse[j][1], exp_pulse[j][0], m_lvl[1], m_lvl[0]};
            for (int k = 0; k < 6; k++) begin
                check($sformatf("dut%0d.%s", j, out_nm[k]), 32'(obs[j][k]), 32'(want[k]));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int rise_k;
        int fall_k;
        int pcnt;
        int pcnt2;
        int hi_cnt;
        int pk [$];
        int exp_off [6] = '{0, 20, 28, 36, 44, 52};
        int toggle_div;

        rst = 1'b1; btn_l = 1'b0; btn_r = 1'b0; sw0 = 1'b0; sw1 = 1'b0;

        // T1: BtnL held through reset
        btn_l = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_reset_outputs", 32'(obs[0]), 32'd0);
        end
        rst = 1'b0;
        rise_k = -1; pcnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 0) check("t1_first_cycle_outputs", 32'(obs[0]), 32'd0);
            if (obs[0][0] && rise_k < 0) rise_k = k;
            if (obs[0][2]) begin
                pcnt++;
                check("t1_pulse_edge", 32'(k), 32'd6);
            end
        end
        check("t1_level_rise_edge", 32'(rise_k), 32'd6);
        check("t1_pulse_count", 32'(pcnt), 32'd1);
        btn_l = 1'b0;
        idle(15);
        $display("T1 reset-held press: rise_k=%0d pulses=%0d", rise_k, pcnt);

        // T2: BtnR bounce then hold
        btn_r = 1'b1; tick();
        btn_r = 1'b0; tick();
        btn_r = 1'b1; tick();
        btn_r = 1'b0; tick();
        btn_r = 1'b1;
        rise_k = -1; pcnt = 0;
        for (int k = 0; k < 18; k++) begin
            tick();
            if (obs[0][1] && rise_k < 0) rise_k = k;
            if (obs[0][3]) pcnt++;
        end
        check("t2_level_rise_edge", 32'(rise_k), 32'd6);
        check("t2_pulse_count", 32'(pcnt), 32'd1);
        btn_r = 1'b0;
        idle(15);
        $display("T2 bounce then hold: rise_k=%0d pulses=%0d", rise_k, pcnt);

        // T3: BtnL long hold with auto-repeat, release 54 cycles after the press pulse
        btn_l = 1'b1;
        fall_k = -1;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (obs[0][2]) pk.push_back(k);
            if (k > 6 && !obs[0][0] && fall_k < 0) fall_k = k;
            if (k == 59) btn_l = 1'b0;
        end
        check("t3_pulse_count", 32'(pk.size()), 32'd6);
        for (int i = 0; i < 6 && i < pk.size(); i++)
            check($sformatf("t3_pulse_offset%0d", i), 32'(pk[i] - pk[0]), 32'(exp_off[i]));
        check("t3_level_fall_edge", 32'(fall_k), 32'd66);
        idle(10);
        $display("T3 auto-repeat: pulses=%0d fall_k=%0d", pk.size(), fall_k);

        // T4: no-repeat instance, two presses
        btn_r = 1'b1;
        pcnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (obs[1][3]) pcnt++;
        end
        btn_r = 1'b0;
        idle(15);
        btn_r = 1'b1;
        pcnt2 = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (obs[1][3]) pcnt2++;
        end
        btn_r = 1'b0;
        idle(15);
        check("t4_first_press_pulses", 32'(pcnt), 32'd1);
        check("t4_second_press_pulses", 32'(pcnt2), 32'd1);
        $display("T4 no-repeat: pulses=%0d then %0d", pcnt, pcnt2);

        // T5: switch glitch rejected, switch hold accepted
        sw0 = 1'b1;
        hi_cnt = 0;
        for (int k = 0; k < 3; k++) begin tick(); if (obs[0][4]) hi_cnt++; end
        sw0 = 1'b0;
        for (int k = 0; k < 10; k++) begin tick(); if (obs[0][4]) hi_cnt++; end
        check("t5_sw0_glitch_rejected", 32'(hi_cnt), 32'd0);
        sw1 = 1'b1;
        rise_k = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (obs[0][5] && rise_k < 0) rise_k = k;
        end
        sw1 = 1'b0;
        idle(10);
        check("t5_sw1_rise_edge", 32'(rise_k), 32'd6);
        $display("T5 switches: sw0_high=%0d sw1_rise_k=%0d", hi_cnt, rise_k);

        // T6: simultaneous press, reset during WAIT, re-debounce
        btn_l = 1'b1; btn_r = 1'b1;
        rise_k = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (obs[0][2] && obs[0][3] && rise_k < 0) rise_k = k;
        end
        check("t6_simultaneous_pulse_edge", 32'(rise_k), 32'd6);
        rst = 1'b1;
        tick();
        check("t6_reset_outputs", 32'(obs[0]), 32'd0);
        rst = 1'b0;
        pcnt = 0; rise_k = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (obs[0][2]) begin
                pcnt++;
                if (rise_k < 0) rise_k = k;
            end
        end
        check("t6_post_reset_pulses", 32'(pcnt), 32'd1);
        check("t6_post_reset_pulse_edge", 32'(rise_k), 32'd6);
        btn_l = 1'b0; btn_r = 1'b0;
        idle(15);
        $display("T6 reset during wait: pulses=%0d first_k=%0d", pcnt, rise_k);

        // Random bouncy stimulus with occasional resets
        toggle_div = 3;
        for (int n = 0; n < 2500; n++) begin
            if (n % 200 == 0) toggle_div = ($urandom_range(0, 1) == 0) ? 3 : 40;
            if ($urandom_range(0, toggle_div - 1) == 0) btn_l = ~btn_l;
            if ($urandom_range(0, toggle_div - 1) == 0) btn_r = ~btn_r;
            if ($urandom_range(0, toggle_div - 1) == 0) sw0 = ~sw0;
            if ($urandom_range(0, toggle_div - 1) == 0) sw1 = ~sw1;
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        $display("Random phase: 2500 cycles");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
